// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction, waits for a load's SRAM response,
// aligns/extends load data and hands {pc, rf_we, rf_waddr, rf_wdata} to WB.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   es_to_ms_valid, es_to_ms_bus      instruction from EX (74 bits)
//   ms_allowin                        MS can accept from EX
//   data_sram_data_ok/rdata           load response (one pulse per load)
//   ws_allowin                        WB can accept this cycle
//   ms_to_ws_valid, ms_to_ws_bus      result to WB (70 bits)
//   ms_valid, ms_rf_waddr             occupancy/destination for decode
//   ms_fwd_valid, ms_fwd_data         forwarding result for decode
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [73:0] es_to_ms_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic        ms_valid,
    output logic [4:0]  ms_rf_waddr,
    output logic        ms_fwd_valid,
    output logic [31:0] ms_fwd_data
);

    logic        r_ms_valid;
    logic [73:0] r_bus;
    logic        r_buf_valid;
    logic [31:0] r_buf;

    logic [31:0] w_pc;
    logic [2:0]  w_load_op;
    logic        w_mem_re;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_alu_result;

    logic        w_ready_go;
    logic        w_leave;
    logic [31:0] w_ld;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_aligned;
    logic [31:0] w_rf_wdata;

    assign {w_pc, w_load_op, w_mem_re, w_rf_we,
            w_rf_waddr, w_alu_result} = r_bus;

    assign w_ready_go = !w_mem_re || r_buf_valid || data_sram_data_ok;
    assign w_leave    = r_ms_valid && w_ready_go && ws_allowin;

    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;

    // A buffered response takes priority: the SRAM bus may have moved on.
    assign w_ld = r_buf_valid ? r_buf : data_sram_rdata;

    always_comb begin
        w_byte       = 8'h00;
        w_half       = 16'h0000;
        w_ld_aligned = w_ld;
        case (w_alu_result[1:0])
            2'd0:    w_byte = w_ld[7:0];
            2'd1:    w_byte = w_ld[15:8];
            2'd2:    w_byte = w_ld[23:16];
            default: w_byte = w_ld[31:24];
        endcase
        // Halfword loads are aligned upstream, so only a[1] matters.
        w_half = w_alu_result[1] ? w_ld[31:16] : w_ld[15:0];
        case (w_load_op)
            3'b001:  w_ld_aligned = {{24{w_byte[7]}}, w_byte};
            3'b010:  w_ld_aligned = {24'h000000, w_byte};
            3'b011:  w_ld_aligned = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_aligned = {16'h0000, w_half};
            default: w_ld_aligned = w_ld;
        endcase
    end

    assign w_rf_wdata = w_mem_re ? w_ld_aligned : w_alu_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid  <= 1'b0;
            r_bus       <= '0;
            r_buf_valid <= 1'b0;
            r_buf       <= '0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (ms_allowin && es_to_ms_valid) begin
                r_bus <= es_to_ms_bus;
            end
            // Leaving empties the buffer, so a load entering on the
            // same edge starts clean.
            if (w_leave) begin
                r_buf_valid <= 1'b0;
            end else if (data_sram_data_ok && r_ms_valid &&
                         w_mem_re && !r_buf_valid) begin
                r_buf_valid <= 1'b1;
                r_buf       <= data_sram_rdata;
            end
        end
    end

    assign ms_to_ws_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
    assign ms_valid     = r_ms_valid;
    assign ms_rf_waddr  = w_rf_waddr;
    // A waiting load reports not-ready so decode stalls instead of forwarding.
    assign ms_fwd_valid = r_ms_valid && w_rf_we && w_ready_go;
    assign ms_fwd_data  = w_rf_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ms_valid;
    logic [4:0]  ms_rf_waddr;
    logic        ms_fwd_valid;
    logic [31:0] ms_fwd_data;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_valid          (ms_valid),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_data       (ms_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: at most one instruction resident
    bit          m_occ;
    bit          m_got;
    logic [73:0] m_ins;
    logic [31:0] m_data;
    int          m_ret = 0;
    int          d_ret = 0;

    // inputs and derived expectations of the current cycle
    bit          c_ev;
    logic [73:0] c_eb;
    bit          c_dok;
    logic [31:0] c_rd;
    bit          c_wsa;
    bit          c_rdy;
    bit          c_leave;
    bit          c_allow;
    logic [31:0] c_wd;

    always @(posedge clk) begin
        if (ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1 && reset === 1'b0)
            d_ret <= d_ret + 1;
    end

    task automatic chk(input string tag, input logic [73:0] got,
                       input logic [73:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [73:0] mk(input logic [31:0] pc,
                                       input logic [2:0] op,
                                       input bit mre, input bit we,
                                       input logic [4:0] wa,
                                       input logic [31:0] alu);
        return {pc, op, mre, we, wa, alu};
    endfunction

    // Load result from plain arithmetic on the 32-bit word.
    function automatic logic [31:0] ref_load(input int op,
                                             input logic [31:0] addr,
                                             input logic [31:0] d);
        int unsigned b;
        int unsigned h;
        int unsigned sh;
        sh = 8 * int'(addr[1:0]);
        b  = (d >> sh) & 32'hFF;
        sh = addr[1] ? 16 : 0;
        h  = (d >> sh) & 32'hFFFF;
        case (op)
            1:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
            2:       return b;
            3:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
            4:       return h;
            default: return d;
        endcase
    endfunction

    task automatic apply(input bit ev, input logic [73:0] eb, input bit dok,
                         input logic [31:0] rd, input bit wsa);
        bit mre;
        bit we;
        @(negedge clk);
        es_to_ms_valid    = ev;
        es_to_ms_bus      = eb;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
        ws_allowin        = wsa;
        c_ev = ev; c_eb = eb; c_dok = dok; c_rd = rd; c_wsa = wsa;
        #1;
        mre     = m_ins[38];
        we      = m_ins[37];
        c_rdy   = m_occ && (!mre || m_got || dok);
        c_leave = c_rdy && wsa;
        c_allow = !m_occ || c_leave;
        chk("ms_valid", ms_valid, m_occ);
        chk("ms_allowin", ms_allowin, c_allow);
        chk("to_ws_valid", ms_to_ws_valid, c_rdy);
        chk("fwd_valid", ms_fwd_valid, c_rdy && we);
        if (m_occ) chk("rf_waddr", ms_rf_waddr, m_ins[36:32]);
        if (c_rdy) begin
            c_wd = mre ? ref_load(int'(m_ins[41:39]), m_ins[31:0],
                                  m_got ? m_data : rd)
                       : m_ins[31:0];
            chk("ws_bus", ms_to_ws_bus,
                {m_ins[73:42], we, m_ins[36:32], c_wd});
            chk("fwd_data", ms_fwd_data, c_wd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_occ && m_ins[38] && !m_got && c_dok && !c_leave) begin
            m_got  = 1'b1;
            m_data = c_rd;
        end
        if (c_leave) begin
            m_occ = 1'b0;
            m_ret++;
        end
        if (c_allow && c_ev) begin
            m_occ = 1'b1;
            m_got = 1'b0;
            m_ins = c_eb;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset             = 1'b1;
            es_to_ms_valid    = 1'b1;
            es_to_ms_bus      = {$urandom, $urandom, 10'($urandom)};
            data_sram_data_ok = 1'b0;
            ws_allowin        = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_ms_valid", ms_valid, 1'b0);
            chk("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
            chk("rst_allowin", ms_allowin, 1'b1);
            chk("rst_fwd_valid", ms_fwd_valid, 1'b0);
        end
        reset = 1'b0;
        m_occ = 1'b0;
        m_got = 1'b0;
        m_ins = '0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  a;
        logic [31:0] exp;
    } ext_t;

    ext_t ext_tab[6] = '{
        '{3'b001, 2'd3, 32'hFFFFFF80},
        '{3'b010, 2'd3, 32'h00000080},
        '{3'b001, 2'd1, 32'h0000007F},
        '{3'b011, 2'd2, 32'hFFFF80FF},
        '{3'b100, 2'd0, 32'h00007F01},
        '{3'b000, 2'd0, 32'h80FF7F01}
    };

    initial begin
        logic [73:0] ins;
        bit          dok;
        reset = 1'b0;
        ws_allowin = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        m_occ = 1'b0;
        m_got = 1'b0;
        m_ins = '0;
        m_data = '0;

        do_reset(2);

        // ALU pass-through, visible one cycle after acceptance
        ins = mk(32'hBFC00010, 3'b000, 1'b0, 1'b1, 5'd5, 32'h12345678);
        apply(1'b1, ins, 1'b0, 32'h0, 1'b1);
        chk("alu_not_yet", ms_to_ws_valid, 1'b0);
        tick();
        apply(1'b0, '0, 1'b0, 32'h0, 1'b1);
        chk("alu_bus", ms_to_ws_bus, {32'hBFC00010, 1'b1, 5'd5, 32'h12345678});
        chk("alu_fwd_valid", ms_fwd_valid, 1'b1);
        chk("alu_fwd_data", ms_fwd_data, 32'h12345678);
        tick();

        // load extension table
        foreach (ext_tab[i]) begin
            ins = mk(32'hBFC00100 + 32'(i * 4), ext_tab[i].op, 1'b1, 1'b1,
                     5'd9, {30'h04000000, ext_tab[i].a});
            apply(1'b1, ins, 1'b0, 32'h0, 1'b1);
            tick();
            apply(1'b0, '0, 1'b1, 32'h80FF7F01, 1'b1);
            chk("ld_ext", ms_fwd_data, ext_tab[i].exp);
            tick();
        end

        // variable-latency load: data_ok three cycles after entry
        ins = mk(32'hBFC00200, 3'b000, 1'b1, 1'b1, 5'd3, 32'h00001000);
        apply(1'b1, ins, 1'b0, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, mk(32'hBFC00204, 3'b000, 1'b0, 1'b1, 5'd4, 32'h1),
                  1'b0, $urandom, 1'b1);
            chk("vl_to_ws_valid", ms_to_ws_valid, 1'b0);
            chk("vl_allowin", ms_allowin, 1'b0);
            chk("vl_fwd_valid", ms_fwd_valid, 1'b0);
            tick();
        end
        apply(1'b0, '0, 1'b1, 32'hCAFEF00D, 1'b1);
        chk("vl_data", ms_fwd_data, 32'hCAFEF00D);
        chk("vl_free", ms_allowin, 1'b1);
        tick();

        // WB back-pressure: response buffered while WB stalls
        ins = mk(32'hBFC00300, 3'b000, 1'b1, 1'b1, 5'd7, 32'h00002000);
        apply(1'b1, ins, 1'b0, 32'h0, 1'b1);
        tick();
        apply(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("bp_allowin0", ms_allowin, 1'b0);
        tick();
        apply(1'b0, '0, 1'b0, 32'h0, 1'b0);
        chk("bp_hold", ms_fwd_data, 32'hDEADBEEF);
        chk("bp_allowin1", ms_allowin, 1'b0);
        tick();
        apply(1'b0, '0, 1'b0, 32'h0, 1'b1);
        chk("bp_release", ms_to_ws_bus[31:0], 32'hDEADBEEF);
        tick();
        apply(1'b0, '0, 1'b0, 32'h0, 1'b1);
        chk("bp_no_dup", ms_to_ws_valid, 1'b0);
        tick();

        // back-to-back loads with data_ok in consecutive cycles
        apply(1'b1, mk(32'hBFC00400, 3'b000, 1'b1, 1'b1, 5'd10, 32'h10),
              1'b0, 32'h0, 1'b1);
        tick();
        apply(1'b1, mk(32'hBFC00404, 3'b000, 1'b1, 1'b1, 5'd11, 32'h14),
              1'b1, 32'h11111111, 1'b1);
        chk("b2b_first", ms_fwd_data, 32'h11111111);
        tick();
        apply(1'b0, '0, 1'b1, 32'h22222222, 1'b1);
        chk("b2b_second", ms_fwd_data, 32'h22222222);
        tick();
        apply(1'b0, '0, 1'b0, 32'h33333333, 1'b1);
        chk("b2b_empty", ms_valid, 1'b0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!(m_occ && m_ins[38] && !m_got) && $urandom_range(0, 299) == 0)
                do_reset(1);
            ins = mk($urandom, 3'($urandom_range(0, 7)), 1'($urandom),
                     1'($urandom), 5'($urandom), $urandom);
            dok = m_occ && m_ins[38] && !m_got && ($urandom_range(0, 2) == 0);
            apply(1'($urandom), ins, dok, $urandom,
                  $urandom_range(0, 9) < 7);
            tick();
        end

        apply(1'b0, '0, 1'b0, 32'h0, 1'b0);
        chk("retired", 74'(d_ret), 74'(m_ret));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, sitting between the execute stage (upstream) and the write-back stage (downstream).
- Holds one instruction and waits for the data-SRAM read response of a load whose request was issued in EX.
- Aligns and sign- or zero-extends the load data, then forwards {pc, rf_we, rf_waddr, rf_wdata} to WB using the valid/allowin handshake.
- Exports destination and result to decode for hazard detection and forwarding.

Parameters:
- None. Bus widths come from cpu.vh: `ES_TO_MS_BUS_WD = 74, `MS_TO_WS_BUS_WD = 70.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- ws_allowin  input  1  WB can accept this cycle
- ms_allowin  output  1  MS can accept from EX
- es_to_ms_valid  input  1  EX presents an instruction
- es_to_ms_bus  input  74  {pc[31:0], load_op[2:0], mem_re, rf_we, rf_waddr[4:0], alu_result[31:0]}
- data_sram_data_ok  input  1  read response valid (one pulse per issued load)
- data_sram_rdata  input  32  read data, valid with data_ok
- ms_to_ws_valid  output  1  instruction ready for WB
- ms_to_ws_bus  output  70  {pc, rf_we, rf_waddr, rf_wdata}
- ms_valid  output  1  stage occupied (to ds)
- ms_rf_waddr  output  5  destination register (to ds)
- ms_fwd_valid  output  1  result available for forwarding
- ms_fwd_data  output  32  result value for forwarding

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: ms_valid=0, bus register=0, rdata_buf_valid=0, rdata_buf=0. Consequently ms_to_ws_valid=0, ms_fwd_valid=0, ms_allowin=1.
- Handshake logic:
  - ms_ready_go = !mem_re || rdata_buf_valid || data_sram_data_ok
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)
  - ms_to_ws_valid = ms_valid && ms_ready_go
- ms_valid: when ms_allowin is 1, ms_valid <= es_to_ms_valid.
- Bus register: loads es_to_ms_bus when ms_allowin && es_to_ms_valid; otherwise holds.
- Leave event: ms_valid && ms_ready_go && ws_allowin.
- Response buffer:
  - If data_ok arrives while ms_valid && mem_re && !rdata_buf_valid and there is no leave event that cycle, capture rdata into rdata_buf and set rdata_buf_valid.
  - Clear rdata_buf_valid on the leave event. If a new load enters on that same cycle, it starts with the buffer empty.
  - data_ok when ms_valid=0, mem_re=0 or the buffer is already full is ignored; the upstream protocol forbids it.
- Load data source: ld = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- Load alignment, with a = alu_result[1:0]:
  - load_op 000 (lw): ld
  - load_op 001 (lb): sign-extended byte a of ld
  - load_op 010 (lbu): zero-extended byte a of ld
  - load_op 011 (lh): sign-extended half a[1] of ld
  - load_op 100 (lhu): zero-extended half a[1] of ld
  - Other load_op values are treated as lw.
  - Misaligned addresses are excluded upstream; lh/lhu ignore a[0].
- Write data: rf_wdata = mem_re ? aligned load : alu_result.
- Output bus: ms_to_ws_bus = {pc, rf_we, rf_waddr, rf_wdata}. It is driven from the register even when ms_valid=0; WB qualifies it with valid.
- Decode-facing outputs:
  - ms_rf_waddr = registered rf_waddr
  - ms_fwd_valid = ms_valid && rf_we && ms_ready_go
  - ms_fwd_data = rf_wdata
  - While a load waits, ms_fwd_valid=0 so decode stalls.
- Latency:
  - Non-load: 1 cycle in MS when ws_allowin=1.
  - Load: leaves in the cycle data_ok is seen, or in the first cycle ws_allowin=1 after that.
- Back-pressure: while ws_allowin=0 with a ready instruction, the bus register and buffer hold and ms_allowin=0.
- Reset mid-operation: the stage is cleared and buffered data is discarded. Reset is only asserted with no outstanding SRAM read.

Test Plan:
- Reset: assert reset 2 cycles with es_to_ms_valid=1 -> ms_valid=0, ms_to_ws_valid=0, ms_allowin=1; after release, the first instruction appears at ms_to_ws_valid one cycle after it is accepted.
- ALU pass-through: pc=0xBFC00010, rf_we=1, waddr=5, alu_result=0x12345678, mem_re=0, ws_allowin=1 -> next cycle ms_to_ws_bus={0xBFC00010,1,5,0x12345678}, ms_fwd_valid=1, ms_fwd_data=0x12345678.
- Load extension with rdata=0x80FF7F01:
  - lb, a=3 -> 0xFFFFFF80
  - lbu, a=3 -> 0x00000080
  - lb, a=1 -> 0x0000007F
  - lh, a=2 -> 0xFFFF80FF
  - lhu, a=0 -> 0x00007F01
  - lw -> 0x80FF7F01
- Variable-latency load: data_ok arrives 3 cycles after the load enters -> ms_to_ws_valid=0 and ms_allowin=0 for 3 cycles, ms_fwd_valid=0; data is correct on the 4th cycle and the stage frees.
- WB back-pressure: data_ok=1 (rdata=0xDEADBEEF) while ws_allowin=0 for 2 cycles, and data_sram_rdata changes to 0 afterwards -> buffer holds, rf_wdata=0xDEADBEEF when ws_allowin rises, instruction leaves once with no duplicate.
- Back-to-back loads: two lw's with data_ok in consecutive cycles and ws_allowin=1 -> both reach WB in consecutive cycles with correct data; the buffer is never set.
